bcd_serial_adder: RTL

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_digit_add.sv | 27 ++
 rtl/bcd_serial_adder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
// Holds the FSM state encoding, digit constants and the index-width helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         DIGIT_W  = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    // A single-digit adder still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal correction.
// Zero latency; no flow control.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] w_raw;

    assign w_raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

    // Out-of-range digits go through the same correction; wrap is intentional.
    always_comb begin
        s    = w_raw[3:0];
        cout = 1'b0;
        if (w_raw > {1'b0, BCD_MAX}) begin
            s    = w_raw[3:0] + BCD_CORR;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one digit per clock, least significant first.
// Done pulses DIGITS+1 edges after an accepted Start; Start is ignored while Busy.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      Start,
    input  logic [DIGIT_W*DIGITS-1:0] A,
    input  logic [DIGIT_W*DIGITS-1:0] B,
    input  logic                      Cin,
    output logic                      Busy,
    output logic                      Done,
    output logic [DIGIT_W*DIGITS-1:0] Sum,
    output logic                      Carry,
    output logic                      Invalid
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = idx_width(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t           r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic [IDX_W-1:0] r_idx;
    logic             r_c;
    logic             r_carry;
    logic             r_invalid;
    logic             r_done;

    logic [3:0]       w_a_dig;
    logic [3:0]       w_b_dig;
    logic [3:0]       w_s_dig;
    logic             w_cout;
    logic             w_invalid;

    // Select the operand digits addressed by the current index.
    always_comb begin
        w_a_dig = '0;
        w_b_dig = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_dig = r_a[i*DIGIT_W +: DIGIT_W];
                w_b_dig = r_b[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    always_comb begin
        w_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (A[i*DIGIT_W +: DIGIT_W] > BCD_MAX || B[i*DIGIT_W +: DIGIT_W] > BCD_MAX) begin
                w_invalid = 1'b1;
            end
        end
    end

    bcd_digit_add u_digit_add (
        .a    (w_a_dig),
        .b    (w_b_dig),
        .cin  (r_c),
        .s    (w_s_dig),
        .cout (w_cout)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            r_idx     <= '0;
            r_c       <= 1'b0;
            r_carry   <= 1'b0;
            r_invalid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_a       <= A;
                        r_b       <= B;
                        r_c       <= Cin;
                        r_idx     <= '0;
                        r_sum     <= '0;
                        r_carry   <= 1'b0;
                        r_invalid <= w_invalid;
                        r_state   <= ADD;
                    end
                end
                ADD: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_sum[i*DIGIT_W +: DIGIT_W] <= w_s_dig;
                        end
                    end
                    r_c <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_carry <= w_cout;
                        r_done  <= 1'b1;
                        r_idx   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Busy    = (r_state != IDLE);
    assign Done    = r_done;
    assign Sum     = r_sum;
    assign Carry   = r_carry;
    assign Invalid = r_invalid;

endmodule
